// File: rtl/instr_encoder.sv
// Instruction encoder/loader: packs decoded ARMv4 fields into a 32-bit word and
// writes it to instruction memory at sequential word addresses.
//
// state   | meaning
// s_idle  | ready for a field bundle
// s_write | write request held on the memory port until mem_ack
// s_full  | 2^DEPTH_LOG2 words written; waits for clear or reset
module instr_encoder #(
    parameter int          DEPTH_LOG2 = 6,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Cond,
    input  logic [1:0]            Op,
    input  logic [5:0]            Funct,
    input  logic [3:0]            Rn,
    input  logic [3:0]            Rd,
    input  logic [11:0]           Src2,
    input  logic                  clear,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  err
);

    typedef enum logic [1:0] {
        s_idle  = 2'd0,
        s_write = 2'd1,
        s_full  = 2'd2
    } state_t;

    localparam logic [DEPTH_LOG2:0] depth_words = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ptr_one     = {{DEPTH_LOG2{1'b0}}, 1'b1};

    state_t              state, state_next;
    logic [DEPTH_LOG2:0] wr_ptr;
    logic                legal;
    logic                accept;
    logic                ack_done;
    logic                last_word;
    logic [31:0]         word;
    logic [31:0]         word_addr;

    assign in_ready  = (state == s_idle) && !reset && !clear;
    assign full      = (state == s_full);
    assign accept    = in_valid && in_ready;
    assign ack_done  = (state == s_write) && mem_ack;
    assign last_word = ((wr_ptr + ptr_one) == depth_words);
    assign count     = wr_ptr;
    assign word_addr = BASE_ADDR + {{(32 - DEPTH_LOG2 - 3){1'b0}}, wr_ptr, 2'b00};

    // Branch: the 20-bit {Rn,Rd,Src2} offset is sign-extended into imm24.
    always_comb begin
        legal = (Op != 2'b11) && (Cond != 4'b1111);
        if (Op == 2'b10)
            word = {Cond, 3'b101, Funct[4], {4{Rn[3]}}, Rn, Rd, Src2};
        else
            word = {Cond, Op, Funct, Rn, Rd, Src2};
    end

    always_comb begin
        state_next = state;
        case (state)
            s_idle:  if (accept && legal) state_next = s_write;
            s_write: if (mem_ack) state_next = last_word ? s_full : s_idle;
            s_full:  state_next = s_full;
            default: state_next = s_idle;
        endcase
        if (clear) state_next = s_idle;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= s_idle;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 32'h0;
        end else if (clear) begin
            wr_ptr   <= '0;
            err      <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= BASE_ADDR;
        end else begin
            if (accept && !legal) err <= 1'b1;
            if (accept && legal) begin
                mem_we    <= 1'b1;
                mem_addr  <= word_addr;
                mem_wdata <= word;
            end
            if (ack_done) begin
                mem_we <= 1'b0;
                wr_ptr <= wr_ptr + ptr_one;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a random stream
// compared against an arithmetic encoding model and an expected-write queue.
module tb_instr_encoder;

    localparam int          DL   = 2;
    localparam int          NWDS = 4;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        reset, in_valid, clear, mem_ack;
    logic        in_ready, mem_we, full, err;
    logic [3:0]  Cond, Rn, Rd;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic [11:0] Src2;
    logic [31:0] mem_addr, mem_wdata;
    logic [DL:0] count;

    instr_encoder #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Cond(Cond), .Op(Op), .Funct(Funct), .Rn(Rn), .Rd(Rd), .Src2(Src2),
        .clear(clear), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int wr_cyc[$];
    int model_ptr = 0;
    int model_cnt = 0;
    bit model_err = 0;
    int cyc = 0;
    int wcnt = 0;
    int ack_delay = 0;
    bit ack_force = 0;
    bit chk_en = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int unsigned c, o, f, n, d, s);
        int unsigned off;
        if (o == 2) begin
            off = n * 65536 + d * 4096 + s;
            if (off >= 32'h8_0000) off = off + 32'hF0_0000;
            return c * 32'h1000_0000 + 32'h0A00_0000 + ((f / 16) % 2) * 32'h100_0000 + off;
        end
        return c * 32'h1000_0000 + o * 32'h400_0000 + f * 32'h10_0000 + n * 65536 + d * 4096 + s;
    endfunction

    // memory responder and held-write checker
    always @(negedge clk) begin
        if (chk_en && mem_we === 1'b1) begin
            if (exp_addr.size() == 0) check_eq("spurious_we", 32'd1, 32'd0);
            else begin
                check_eq("we_addr", mem_addr, exp_addr[0]);
                check_eq("we_data", mem_wdata, exp_data[0]);
            end
        end
        if (mem_we === 1'b1) wcnt++;
        else wcnt = 0;
        mem_ack = ack_force || (mem_we === 1'b1 && wcnt > ack_delay);
    end

    always @(posedge clk) begin
        cyc++;
        if (chk_en && !reset && !clear && mem_we === 1'b1 && mem_ack) begin
            if (exp_addr.size() == 0) check_eq("unexp_write", 32'd1, 32'd0);
            else begin
                void'(exp_addr.pop_front());
                void'(exp_data.pop_front());
            end
            model_cnt++;
            wr_cyc.push_back(cyc);
        end
    end

    task automatic model_restart();
        exp_addr.delete();
        exp_data.delete();
        model_ptr = 0;
        model_cnt = 0;
        model_err = 0;
    endtask

    task automatic send(input int unsigned c, o, f, n, d, s);
        int budget;
        bit legal;
        #1;
        Cond = 4'(c); Op = 2'(o); Funct = 6'(f); Rn = 4'(n); Rd = 4'(d); Src2 = 12'(s);
        in_valid = 1'b1;
        budget = 0;
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        legal = (o != 3) && (c != 15);
        if (legal) begin
            exp_addr.push_back(BASE + 32'(4 * model_ptr));
            exp_data.push_back(ref_word(c, o, f, n, d, s));
            model_ptr++;
        end else model_err = 1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check_eq("we_latency", 32'(mem_we), 32'(legal));
        check_eq("err_flag", 32'(err), 32'(model_err));
    endtask

    task automatic wait_drain();
        int budget = 0;
        while ((exp_addr.size() != 0 || mem_we !== 1'b0) && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 300) check_eq("drain_timeout", 32'd0, 32'd1);
        check_eq("count", 32'(count), 32'(model_cnt));
        check_eq("full", 32'(full), 32'(model_cnt == NWDS));
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        model_restart();
        @(negedge clk);
        check_eq("clr_count", 32'(count), 32'd0);
        check_eq("clr_err", 32'(err), 32'd0);
        check_eq("clr_we", 32'(mem_we), 32'd0);
        check_eq("clr_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; clear = 1'b0; mem_ack = 1'b0;
        Cond = 0; Op = 0; Funct = 0; Rn = 0; Rd = 0; Src2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("ready_in_reset", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1;
        @(negedge clk);
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_addr", mem_addr, BASE);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);

        // ADD R1,R2,#5 with ack one cycle after mem_we
        ack_delay = 1;
        check_eq("add_word", ref_word(14, 0, 6'b101000, 2, 1, 12'h005), 32'hE282_1005);
        send(14, 0, 6'b101000, 2, 1, 12'h005);
        wait_drain();
        check_eq("add_cnt", 32'(count), 32'd1);

        // LDR then B -8 with ack held high: one word every 2 cycles
        pulse_clear();
        ack_force = 1;
        wr_cyc.delete();
        send(14, 1, 6'b011001, 0, 3, 12'h008);
        send(14, 2, 6'b000000, 4'hF, 4'hF, 12'hFFE);
        wait_drain();
        ack_force = 0;
        check_eq("thru_nwr", 32'(wr_cyc.size()), 32'd2);
        if (wr_cyc.size() == 2) check_eq("thru_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd2);

        // illegal bundle between two legal ones
        pulse_clear();
        ack_delay = 0;
        send(14, 0, 6'b001000, 1, 2, 12'h003);
        send(14, 3, 6'b000000, 1, 2, 12'h003);
        send(15, 0, 6'b001000, 1, 2, 12'h003);
        send(0, 0, 6'b000100, 4, 5, 12'h006);
        wait_drain();
        check_eq("ill_err", 32'(err), 32'd1);
        check_eq("ill_cnt", 32'(count), 32'd2);

        // fill to FULL, 5th bundle refused, clear restarts at BASE
        pulse_clear();
        for (int i = 0; i < NWDS; i++) send(14, 0, 6'b001000, i, i + 1, 12'(i * 7));
        wait_drain();
        Cond = 14; Op = 0; Funct = 6'b001000; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("full_ready", 32'(in_ready), 32'd0);
            check_eq("full_flag", 32'(full), 32'd1);
        end
        in_valid = 1'b0;
        check_eq("full_cnt", 32'(count), 32'(NWDS));
        pulse_clear();
        send(1, 1, 6'b011001, 7, 8, 12'h123);
        wait_drain();

        // mem_ack withheld 10 cycles; a waiting bundle is not accepted
        pulse_clear();
        ack_delay = 10;
        send(14, 0, 6'b011010, 3, 4, 12'hABC);
        #1;
        Cond = 14; Op = 1; Funct = 6'b011001; Rn = 1; Rd = 2; Src2 = 12'h010;
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check_eq("hold_ready", 32'(in_ready), 32'd0);
            check_eq("hold_we", 32'(mem_we), 32'd1);
        end
        in_valid = 1'b0;
        wait_drain();
        check_eq("hold_cnt", 32'(count), 32'd1);

        // clear together with mem_ack while in WRITE
        ack_delay = 0;
        send(15, 2, 0, 0, 0, 0);
        ack_delay = 1000;
        send(14, 0, 6'b000000, 9, 9, 12'h999);
        @(posedge clk);
        #1 clear = 1'b1; ack_force = 1; mem_ack = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0; ack_force = 0;
        model_restart();
        @(negedge clk);
        check_eq("clrw_we", 32'(mem_we), 32'd0);
        check_eq("clrw_cnt", 32'(count), 32'd0);
        check_eq("clrw_err", 32'(err), 32'd0);

        // reset mid-WRITE
        send(14, 3, 0, 0, 0, 0);
        send(14, 0, 6'b011111, 15, 14, 12'hFED);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_eq("rstw_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_restart();
        @(negedge clk);
        check_eq("rstw_we", 32'(mem_we), 32'd0);
        check_eq("rstw_addr", mem_addr, BASE);
        check_eq("rstw_wdata", mem_wdata, 32'd0);
        check_eq("rstw_cnt", 32'(count), 32'd0);
        check_eq("rstw_full", 32'(full), 32'd0);
        check_eq("rstw_err", 32'(err), 32'd0);

        // random stream
        for (int k = 0; k < 60; k++) begin
            int unsigned c, o;
            if (model_ptr == NWDS) begin
                wait_drain();
                pulse_clear();
            end else if ($urandom_range(0, 15) == 0) pulse_clear();
            ack_delay = $urandom_range(0, 3);
            c = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 14);
            o = $urandom_range(0, 3);
            send(c, o, $urandom_range(0, 63), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 4095));
        end
        wait_drain();
        check_eq("final_err", 32'(err), 32'(model_err));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
